// File: rtl/encoder_conditioner_if.sv
// Signal bundle between the Hall encoder pins and the conditioner.
// The master drives the raw sensor lines; the slave (conditioner) drives the conditioned outputs.
interface encoder_conditioner_if;
   logic        sa_raw;
   logic        sb_raw;
   logic        sa_clean;
   logic        sb_clean;
   logic        sa_rise;
   logic        direction;
   logic        dir_valid;
   logic [15:0] glitch_count;

   modport master (
      output sa_raw, sb_raw,
      input  sa_clean, sb_clean, sa_rise, direction, dir_valid, glitch_count
   );

   modport slave (
      input  sa_raw, sb_raw,
      output sa_clean, sb_clean, sa_rise, direction, dir_valid, glitch_count
   );
endinterface

// File: rtl/encoder_conditioner.sv
// PmodHB3 SA/SB conditioner: 2-flop sync, per-channel run-length glitch filter, SA rise strobe.
// Define ENC_DIR_DETECT_EN to build the SB path and the direction flag; otherwise only SA is conditioned.
module encoder_conditioner #(
   parameter int unsigned FILTER_CYCLES = 16
) (
   input  logic                  clock,
   input  logic                  system_reset,
   encoder_conditioner_if.slave  enc_if
);

   localparam logic [15:0] LP_LAST = 16'(FILTER_CYCLES - 1);

   logic [1:0]  r_sa_sync;
   logic        r_sa_clean;
   logic [15:0] r_sa_cnt;
   logic        r_sa_rise;
   logic [15:0] r_glitch_count;

   logic        w_sa_clean_nxt;
   logic [15:0] w_sa_cnt_nxt;
   logic        w_sa_glitch;
   logic        w_sa_rise_nxt;
   logic        w_sb_glitch;
   logic [1:0]  w_glitch_inc;
   logic [16:0] w_glitch_sum;

   // A return to the clean level with a non-zero run count means the excursion was too short.
   always_comb begin
      w_sa_clean_nxt = r_sa_clean;
      w_sa_cnt_nxt   = r_sa_cnt;
      w_sa_glitch    = 1'b0;
      if (r_sa_sync[1] == r_sa_clean) begin
         if (r_sa_cnt != 16'd0) begin
            w_sa_cnt_nxt = 16'd0;
            w_sa_glitch  = 1'b1;
         end
      end else if (r_sa_cnt == LP_LAST) begin
         w_sa_clean_nxt = r_sa_sync[1];
         w_sa_cnt_nxt   = 16'd0;
      end else begin
         w_sa_cnt_nxt = r_sa_cnt + 16'd1;
      end
   end

   assign w_sa_rise_nxt = w_sa_clean_nxt & ~r_sa_clean;

   always_ff @(posedge clock or posedge system_reset) begin
      if (system_reset) begin
         r_sa_sync  <= 2'b00;
         r_sa_clean <= 1'b0;
         r_sa_cnt   <= 16'd0;
         r_sa_rise  <= 1'b0;
      end else begin
         r_sa_sync  <= {r_sa_sync[0], enc_if.sa_raw};
         r_sa_clean <= w_sa_clean_nxt;
         r_sa_cnt   <= w_sa_cnt_nxt;
         r_sa_rise  <= w_sa_rise_nxt;
      end
   end

`ifdef ENC_DIR_DETECT_EN
   logic [1:0]  r_sb_sync;
   logic        r_sb_clean;
   logic [15:0] r_sb_cnt;
   logic        r_direction;
   logic        r_dir_valid;

   logic        w_sb_clean_nxt;
   logic [15:0] w_sb_cnt_nxt;

   always_comb begin
      w_sb_clean_nxt = r_sb_clean;
      w_sb_cnt_nxt   = r_sb_cnt;
      w_sb_glitch    = 1'b0;
      if (r_sb_sync[1] == r_sb_clean) begin
         if (r_sb_cnt != 16'd0) begin
            w_sb_cnt_nxt = 16'd0;
            w_sb_glitch  = 1'b1;
         end
      end else if (r_sb_cnt == LP_LAST) begin
         w_sb_clean_nxt = r_sb_sync[1];
         w_sb_cnt_nxt   = 16'd0;
      end else begin
         w_sb_cnt_nxt = r_sb_cnt + 16'd1;
      end
   end

   // Direction samples the pre-update SB level, so a same-edge SB change is not seen.
   always_ff @(posedge clock or posedge system_reset) begin
      if (system_reset) begin
         r_sb_sync   <= 2'b00;
         r_sb_clean  <= 1'b0;
         r_sb_cnt    <= 16'd0;
         r_direction <= 1'b0;
         r_dir_valid <= 1'b0;
      end else begin
         r_sb_sync  <= {r_sb_sync[0], enc_if.sb_raw};
         r_sb_clean <= w_sb_clean_nxt;
         r_sb_cnt   <= w_sb_cnt_nxt;
         if (w_sa_rise_nxt) begin
            r_direction <= r_sb_clean;
            r_dir_valid <= 1'b1;
         end
      end
   end

   assign enc_if.sb_clean  = r_sb_clean;
   assign enc_if.direction = r_direction;
   assign enc_if.dir_valid = r_dir_valid;
`else
   assign w_sb_glitch      = 1'b0;
   assign enc_if.sb_clean  = 1'b0;
   assign enc_if.direction = 1'b0;
   assign enc_if.dir_valid = 1'b0;
`endif

   // Both channels may glitch in one cycle; saturate rather than wrap.
   assign w_glitch_inc = {1'b0, w_sa_glitch} + {1'b0, w_sb_glitch};
   assign w_glitch_sum = {1'b0, r_glitch_count} + {15'd0, w_glitch_inc};

   always_ff @(posedge clock or posedge system_reset) begin
      if (system_reset) begin
         r_glitch_count <= 16'd0;
      end else begin
         r_glitch_count <= w_glitch_sum[16] ? 16'hFFFF : w_glitch_sum[15:0];
      end
   end

   assign enc_if.sa_clean     = r_sa_clean;
   assign enc_if.sa_rise      = r_sa_rise;
   assign enc_if.glitch_count = r_glitch_count;

endmodule
